// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared constants for the buffered UART transmitter
package uart_tx_fifo_pkg;

  // Transmit FSM state encodings (2-bit, legacy-compatible)
  localparam logic [1:0] UTX_IDLE  = 2'd0;
  localparam logic [1:0] UTX_START = 2'd1;
  localparam logic [1:0] UTX_DATA  = 2'd2;
  localparam logic [1:0] UTX_STOP  = 2'd3;

  // Width of a counter that must hold values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - single-clock FIFO with occupancy count
module uart_tx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Flags come straight from the registered count, so a push is judged on
  // the pre-edge state even when a pop happens on the same edge.
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written only on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push - pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        sys_clk_i,
  input  logic        sys_rstn_i,
  input  logic        uart_wr_i,
  input  logic [7:0]  uart_dat_i,
  output logic        uart_tx,
  output logic        fifo_full_o,
  output logic [AW:0] fifo_count_o,
  output logic        tx_busy_o,
  output logic        overflow_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          baud_wrap;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst_n (sys_rstn_i),
    .push  (uart_wr_i),
    .din   (uart_dat_i),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count_o),
    .full  (fifo_full_o),
    .empty (fifo_empty)
  );

  assign baud_wrap = (baud_cnt == BAUD_MAX);

  // The shifter takes a new byte either from idle or at the very end of a
  // stop bit, which is what lets frames run back-to-back with no gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == UTX_IDLE) || ((state == UTX_STOP) && baud_wrap));

  assign uart_tx   = tx_q;
  assign tx_busy_o = (state != UTX_IDLE);

  // Sticky record of any push dropped because the FIFO was full
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      overflow_o <= 1'b0;
    end else if (uart_wr_i && fifo_full_o) begin
      overflow_o <= 1'b1;
    end
  end

  // Transmit FSM: baud timing, bit sequencing, shift register and line driver
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state    <= UTX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        UTX_IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          if (fifo_pop) begin
            shreg <= fifo_dout;
            state <= UTX_START;
            tx_q  <= 1'b0;
          end
        end
        UTX_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= UTX_DATA;
            tx_q     <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UTX_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= UTX_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shreg <= fifo_dout;
              state <= UTX_START;
              tx_q  <= 1'b0;
            end else begin
              state <= UTX_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for the buffered UART transmitter
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int AW       = $clog2(DEPTH);
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic [7:0]    dat = 8'h00;
  logic          tx;
  logic          full;
  logic [AW:0]   count;
  logic          busy;
  logic          ovf;

  int tests = 0;
  int failed = 0;

  // Reference model: bytes waiting, byte on the wire, cycles of frame left
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_rem = 0;
  logic       m_ovf = 1'b0;

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rstn_i   (rst_n),
    .uart_wr_i    (wr),
    .uart_dat_i   (dat),
    .uart_tx      (tx),
    .fifo_full_o  (full),
    .fifo_count_o (count),
    .tx_busy_o    (busy),
    .overflow_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic logic model_line();
    int phase;
    int b;
    if (m_rem == 0) return 1'b1;
    phase = FRAME - m_rem;
    b = phase / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  // One clock edge of the abstract transmitter: decisions use pre-edge state
  task automatic model_step(input logic w, input logic [7:0] d);
    logic was_full;
    logic do_pop;
    was_full = (mq.size() == DEPTH);
    do_pop = (mq.size() > 0) && (m_rem <= 1);
    if (w && was_full) m_ovf = 1'b1;
    if (do_pop) begin
      m_cur = mq.pop_front();
      m_rem = FRAME;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (w && !was_full) begin
      mq.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    chk("uart_tx", int'(tx), int'(model_line()));
    chk("fifo_count", int'(count), mq.size());
    chk("fifo_full", int'(full), int'(mq.size() == DEPTH));
    chk("tx_busy", int'(busy), int'(m_rem > 0));
    chk("overflow", int'(ovf), int'(m_ovf));
  endtask

  task automatic cyc(input logic w, input logic [7:0] d);
    @(negedge clk);
    wr = w;
    dat = d;
    @(posedge clk);
    model_step(w, d);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    m_rem = 0;
    m_ovf = 1'b0;
    chk("reset_uart_tx", int'(tx), 1);
    chk("reset_count", int'(count), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overflow", int'(ovf), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) until the model says the next edge ends a stop bit
  task automatic wait_stop_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_rem == 1) begin
        ok = 1'b1;
        break;
      end
      cyc(1'b0, 8'h00);
    end
    chk("stop_end_reached", int'(ok), 1);
  endtask

  // Line decoder: reassembles frames from uart_tx and scores them
  initial begin : monitor
    bit         active;
    int         cnt;
    logic [7:0] byte_v;
    logic [7:0] want;
    active = 1'b0;
    cnt = 0;
    byte_v = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx == 1'b0) begin
          active = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if ((cnt % CPB) == CPB / 2 && cnt > CPB && cnt < 9 * CPB)
          byte_v[cnt/CPB - 1] = tx;
        if (cnt == 9 * CPB + CPB / 2) begin
          chk("stop_bit", int'(tx), 1);
          if (exp_q.size() == 0) begin
            chk("frame_expected", 0, 1);
          end else begin
            want = exp_q.pop_front();
            chk("decoded_byte", int'(byte_v), int'(want));
          end
          active = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    bit ok;
    do_reset();

    // Idle after reset: line high, nothing busy
    idle(1000);

    // Single byte
    cyc(1'b1, 8'h55);
    idle(FRAME + 10);

    // Three back-to-back bytes
    cyc(1'b1, 8'h41);
    cyc(1'b1, 8'h42);
    cyc(1'b1, 8'h43);
    idle(3 * FRAME + 20);

    // Overflow: six pushes into a four-deep FIFO
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h10 + 8'(i));
    idle(5 * FRAME + 20);

    // Push coinciding with a stop->start pop, not full then full
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + 8'(i));
    wait_stop_end(ok);
    cyc(1'b1, 8'h70);
    chk("pushpop_count", int'(count), DEPTH - 1);
    cyc(1'b1, 8'h71);
    chk("filled_full", int'(full), 1);
    wait_stop_end(ok);
    cyc(1'b1, 8'h72);
    chk("dropped_count", int'(count), DEPTH - 1);
    chk("dropped_overflow", int'(ovf), 1);
    idle(5 * FRAME + 20);

    // Reset in the middle of a data bit with two bytes queued
    do_reset();
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'h3C);
    cyc(1'b1, 8'hC3);
    idle(4 * CPB + 3);
    do_reset();
    idle(3 * FRAME);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) cyc(1'b1, 8'($urandom));
      else cyc(1'b0, 8'h00);
    end
    idle(DEPTH * FRAME + FRAME + 20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
